fbna_ifmap_streamer: RTL and testbench

//  Transmit side of the PBC ifmap shift-in interface. Buffers one input-feature-map frame as

---
 rtl/fbna_ifmap_streamer.sv | 150 +++++++++++++++
 tb/tb_fbna_ifmap_streamer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fbna_ifmap_streamer.sv
// fbna_ifmap_streamer: buffers one ifmap frame of LANES-bit columns and replays it into the PBC shift-in bus, followed by zero pad columns
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       load handshake; in_data is one column, in_last marks the frame's final column
//   out_valid/out_data      column shifted into the PBC this cycle (data is 0 when not valid)
//   out_first/out_last      first / last data column of the frame (never set on pad columns)
//   frame_len               columns in the most recently loaded frame
//   busy, done, err_ovf     not idle, pulse on final emitted column, sticky truncation flag
// Optional: define FBNA_STREAM_REPLAY_EN to add the `replay` input, which re-streams the stored frame.
module fbna_ifmap_streamer #(
  parameter int LANES    = 4,
  parameter int DEPTH    = 16,
  parameter int PAD_COLS = 2,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
`ifdef FBNA_STREAM_REPLAY_EN
  input  logic             replay,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  output logic [LANES-1:0] out_data,
  output logic             out_first,
  output logic             out_last,
  output logic [PTR_W:0]   frame_len,
  output logic             busy,
  output logic             done,
  output logic             err_ovf
);
  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;
  localparam int PAD_W = PAD_COLS > 0 ? $clog2(PAD_COLS + 1) : 1;
  localparam logic [PAD_W-1:0] PAD_N = PAD_W'(PAD_COLS);
  localparam logic PAD_NONE = (PAD_COLS == 0);
  state_t state;
  logic [LANES-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PAD_W-1:0] pad_cnt;
  logic accept, last_beat, rep_go, start, start_one, col_last, finish;
  logic [LANES-1:0] start_data;
  logic [PTR_W-1:0] wr_addr;
`ifdef FBNA_STREAM_REPLAY_EN
  assign rep_go = replay && frame_len != '0;
`else
  assign rep_go = 1'b0;
`endif
  assign accept     = in_valid & in_ready;
  assign last_beat  = in_last | (wr_ptr == PTR_W'(DEPTH - 1));
  assign wr_addr    = state == IDLE ? '0 : wr_ptr;
  // From IDLE a frame starts either from the beat just accepted (single-column frame, bypassing
  // the buffer write that happens on the same edge) or, on replay, from the stored buf[0].
  assign start      = accept ? in_last : rep_go;
  assign start_data = accept ? in_data : mem[0];
  assign start_one  = accept | (frame_len == (PTR_W + 1)'(1));
  assign col_last   = {1'b0, rd_ptr} == frame_len - 1'b1;
  // The final column (data when there is no padding, else the last pad) was shown this cycle.
  assign finish     = (state == STREAM && out_last && PAD_NONE) || (state == FLUSH && pad_cnt == PAD_N);
  always_ff @(posedge clock)
    if (accept) mem[wr_addr] <= in_data;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      frame_len <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_ovf   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pad_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            wr_ptr  <= PTR_W'(1);
            err_ovf <= 1'b0;
          end
          if (accept && !in_last) begin
            state <= FILL;
            busy  <= 1'b1;
          end
          if (start) begin
            state     <= STREAM;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= start_data;
            out_first <= 1'b1;
            out_last  <= start_one;
            done      <= PAD_NONE && start_one;
            rd_ptr    <= PTR_W'(1);
            if (accept) frame_len <= (PTR_W + 1)'(1);
          end
        end
        FILL: if (accept) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (last_beat) begin
            state     <= STREAM;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= mem[0];
            out_first <= 1'b1;
            rd_ptr    <= PTR_W'(1);
            frame_len <= {1'b0, wr_ptr} + 1'b1;
            err_ovf   <= !in_last;
          end
        end
        STREAM: if (!out_last) begin
          out_data  <= mem[rd_ptr];
          out_first <= 1'b0;
          out_last  <= col_last;
          done      <= PAD_NONE && col_last;
          rd_ptr    <= rd_ptr + 1'b1;
        end else begin
          state     <= FLUSH;
          out_data  <= '0;
          out_first <= 1'b0;
          out_last  <= 1'b0;
          rd_ptr    <= '0;
          pad_cnt   <= PAD_W'(1);
          done      <= PAD_N == PAD_W'(1);
        end
        FLUSH: begin
          pad_cnt <= pad_cnt + 1'b1;
          done    <= pad_cnt + 1'b1 == PAD_N;
        end
      endcase
      if (finish) begin
        state     <= IDLE;
        busy      <= 1'b0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b0;
        rd_ptr    <= '0;
        pad_cnt   <= '0;
      end
    end
endmodule

// File: tb/tb_fbna_ifmap_streamer.sv
// tb_fbna_ifmap_streamer: directed vector table plus hand sequences for overflow, reset abort, back-to-back and replay
module tb_fbna_ifmap_streamer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic [3:0] in_data = '0;
  logic in_ready, out_valid, out_first, out_last, busy, done, err_ovf;
  logic [3:0] out_data;
  logic [4:0] frame_len;
`ifdef FBNA_STREAM_REPLAY_EN
  logic replay = 1'b0;
`endif
  int pass = 0, total = 0;

  fbna_ifmap_streamer dut (
    .clock(clk), .reset(rst_n),
`ifdef FBNA_STREAM_REPLAY_EN
    .replay(replay),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .frame_len(frame_len), .busy(busy), .done(done), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {logic v; logic [3:0] d; logic l; logic [15:0] exp;} vec_t;
  typedef struct packed {logic [3:0] d; logic f; logic l;} col_t;

  function automatic logic [15:0] pk(logic r, logic ov, logic [3:0] d, logic f, logic l,
                                     logic dn, logic b, logic e, logic [4:0] fl);
    return {r, ov, d, f, l, dn, b, e, fl};
  endfunction

  function automatic vec_t mk(logic v, logic [3:0] d, logic l, logic [15:0] exp);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.exp = exp;
    return t;
  endfunction

  function automatic logic [15:0] now();
    return pk(in_ready, out_valid, out_data, out_first, out_last, done, busy, err_ovf, frame_len);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[14];
  col_t got[$], want[$];
  logic [15:0] rexp[5];

  initial begin
    // {in_valid, in_data, in_last} -> {in_ready,out_valid,out_data,first,last,done,busy,err_ovf,frame_len}
    tbl[0]  = mk(1, 4'hA, 0, pk(1, 0, 4'h0, 0, 0, 0, 1, 0, 0));
    tbl[1]  = mk(1, 4'hB, 0, pk(1, 0, 4'h0, 0, 0, 0, 1, 0, 0));
    tbl[2]  = mk(1, 4'hC, 0, pk(1, 0, 4'h0, 0, 0, 0, 1, 0, 0));
    tbl[3]  = mk(1, 4'hD, 1, pk(0, 1, 4'hA, 1, 0, 0, 1, 0, 4));
    tbl[4]  = mk(1, 4'h5, 0, pk(0, 1, 4'hB, 0, 0, 0, 1, 0, 4));
    tbl[5]  = mk(0, 4'h0, 0, pk(0, 1, 4'hC, 0, 0, 0, 1, 0, 4));
    tbl[6]  = mk(1, 4'h5, 0, pk(0, 1, 4'hD, 0, 1, 0, 1, 0, 4));
    tbl[7]  = mk(0, 4'h0, 0, pk(0, 1, 4'h0, 0, 0, 0, 1, 0, 4));
    tbl[8]  = mk(1, 4'h5, 1, pk(0, 1, 4'h0, 0, 0, 1, 1, 0, 4));
    tbl[9]  = mk(0, 4'h0, 0, pk(1, 0, 4'h0, 0, 0, 0, 0, 0, 4));
    tbl[10] = mk(1, 4'hF, 1, pk(0, 1, 4'hF, 1, 1, 0, 1, 0, 1));
    tbl[11] = mk(0, 4'h0, 0, pk(0, 1, 4'h0, 0, 0, 0, 1, 0, 1));
    tbl[12] = mk(0, 4'h0, 0, pk(0, 1, 4'h0, 0, 0, 1, 1, 0, 1));
    tbl[13] = mk(0, 4'h0, 0, pk(1, 0, 4'h0, 0, 0, 0, 0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", now(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();
    chk("after_release", now(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l;
      tick();
      chk($sformatf("vec%0d", i), now(), tbl[i].exp);
    end

    // reset asserted while column 2 of a 4-column frame is on the bus
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'(7 + i); in_last = (i == 3);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("mid_stream_col2", {28'd0, out_data}, 32'd8);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", now(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_abort_idle", now(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0));

    // 20 beats with no in_last until beat 20: truncation at 16, then back-to-back second frame
    begin
      int idx = 0, cyc = 0, done_cyc = -1, acc16 = -1;
      logic rdy;
      while (cyc < 300 && (idx < 20 || busy)) begin
        in_valid = (idx < 20); in_data = 4'(idx + 1); in_last = (idx == 19);
        rdy = in_ready;
        tick();
        cyc++;
        if (out_valid) got.push_back('{out_data, out_first, out_last});
        if (done && done_cyc < 0) done_cyc = cyc;
        if (rdy && in_valid) begin
          if (idx == 15) begin
            chk("ovf_ready_low", {31'd0, in_ready}, 32'd0);
            chk("ovf_err_set", {31'd0, err_ovf}, 32'd1);
            chk("ovf_frame_len", {27'd0, frame_len}, 32'd16);
          end
          if (idx == 16) acc16 = cyc;
          idx++;
        end
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("ovf_no_timeout", {31'd0, cyc < 300}, 32'd1);
      for (int i = 0; i < 16; i++) want.push_back('{4'(i + 1), i == 0, i == 15});
      repeat (2) want.push_back('{4'h0, 1'b0, 1'b0});
      for (int i = 16; i < 20; i++) want.push_back('{4'(i + 1), i == 16, i == 19});
      repeat (2) want.push_back('{4'h0, 1'b0, 1'b0});
      chk("ovf_col_count", got.size(), 32'd24);
      for (int i = 0; i < 24 && i < got.size(); i++)
        chk($sformatf("ovf_col%0d", i), {26'd0, got[i]}, {26'd0, want[i]});
      chk("b2b_accept_after_done", acc16, done_cyc + 2);
      chk("b2b_err_cleared", {31'd0, err_ovf}, 32'd0);
      chk("b2b_frame_len", {27'd0, frame_len}, 32'd4);
    end

`ifdef FBNA_STREAM_REPLAY_EN
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'(5 + i); in_last = (i == 2);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (5) tick();
    rexp[0] = pk(0, 1, 4'h5, 1, 0, 0, 1, 0, 3);
    rexp[1] = pk(0, 1, 4'h6, 0, 0, 0, 1, 0, 3);
    rexp[2] = pk(0, 1, 4'h7, 0, 1, 0, 1, 0, 3);
    rexp[3] = pk(0, 1, 4'h0, 0, 0, 0, 1, 0, 3);
    rexp[4] = pk(0, 1, 4'h0, 0, 0, 1, 1, 0, 3);
    replay = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      replay = 1'b0;
      chk($sformatf("replay%0d", k), now(), rexp[k]);
    end
    tick();
    replay = 1'b1; in_valid = 1'b1; in_data = 4'h3; in_last = 1'b1;
    tick();
    replay = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("replay_load_wins", now(), pk(0, 1, 4'h3, 1, 1, 0, 1, 0, 1));
    repeat (3) tick();
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
